// File: rtl/me_pkg.sv
// rtl/me_pkg.sv - shared motion-estimation constants and types
package me_pkg;
  localparam int PIXEL      = 8;
  localparam int LANES      = 8;
  localparam int BANK_DEPTH = 96;
  localparam int BANK_AW    = 7;

  typedef logic [LANES*PIXEL-1:0] ref_word_t;
endpackage

// File: rtl/ref_bank_ram.sv
// rtl/ref_bank_ram.sv - simple dual-port RAM, one write port, one registered read-first read port
module ref_bank_ram
  import me_pkg::*;
#(
  parameter int DW    = LANES*PIXEL,
  parameter int DEPTH = BANK_DEPTH,
  parameter int AW    = BANK_AW
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Read and write sit in one block so a same-address collision returns the old word.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ref_bank.sv
// rtl/ref_bank.sv - reference-pixel bank: gated writes, active-low reads, range masking
module ref_bank
  import me_pkg::*;
#(
  parameter int PIXEL = me_pkg::PIXEL,
  parameter int LANES = me_pkg::LANES,
  parameter int DEPTH = BANK_DEPTH,
  parameter int AW    = BANK_AW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [LANES*PIXEL-1:0] ref_in,
  input  logic                   Bank_sel,
  input  logic [AW-1:0]          write_address,
  input  logic [AW-1:0]          address,
  input  logic                   rd_en,
  output logic [LANES*PIXEL-1:0] ref_ou
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic                   wr_in_range;
  logic                   rd_in_range;
  logic                   wr_fire;
  logic                   rd_req;
  logic                   ram_re;
  logic                   zero_q;
  logic                   zero_d;
  logic [LANES*PIXEL-1:0] ram_rdata;

  assign wr_in_range = ({1'b0, write_address} < DEPTH_W);
  assign rd_in_range = ({1'b0, address} < DEPTH_W);

  // rst_n is active-high; if-conditions keep an X on rd_en from counting as a read.
  always_comb begin
    wr_fire = 1'b0;
    rd_req  = 1'b0;
    if (rst_n == 1'b0 && Bank_sel == 1'b0 && wr_in_range) begin
      wr_fire = 1'b1;
    end
    if (rst_n == 1'b0 && rd_en == 1'b0) begin
      rd_req = 1'b1;
    end
  end

  assign ram_re = rd_req & rd_in_range;

  always_comb begin
    zero_d = zero_q;
    if (rd_req) begin
      zero_d = ~rd_in_range;
    end
  end

  // The RAM output register carries no reset; zero_q forces the visible word to 0 instead.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      zero_q <= 1'b1;
    end else begin
      zero_q <= zero_d;
    end
  end

  ref_bank_ram #(
    .DW    (LANES*PIXEL),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_fire),
    .waddr_i (write_address),
    .wdata_i (ref_in),
    .re_i    (ram_re),
    .raddr_i (address),
    .rdata_o (ram_rdata)
  );

  assign ref_ou = zero_q ? '0 : ram_rdata;

endmodule

// File: tb/tb_ref_bank.sv
// tb/tb_ref_bank.sv - randomized and directed self-checking bench for ref_bank
module tb_ref_bank;

  logic        clk;
  logic        rst_n;
  logic [63:0] ref_in;
  logic        Bank_sel;
  logic [6:0]  write_address;
  logic [6:0]  address;
  logic        rd_en;
  logic [63:0] ref_ou;

  int total = 0;
  int bad   = 0;

  logic [63:0] model_mem [96];
  bit          known [96];
  logic [63:0] exp_ou;

  ref_bank dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ref_in        (ref_in),
    .Bank_sel      (Bank_sel),
    .write_address (write_address),
    .address       (address),
    .rd_en         (rd_en),
    .ref_ou        (ref_ou)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: read sees the array before this cycle's write.
  task automatic tick();
    if (rst_n === 1'b1) begin
      exp_ou = 64'h0;
    end else begin
      if (rd_en === 1'b0) begin
        exp_ou = (address < 7'd96) ? model_mem[address] : 64'h0;
      end
      if (Bank_sel === 1'b0 && write_address < 7'd96) begin
        model_mem[write_address] = ref_in;
        known[write_address]     = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic test_reset();
    rst_n = 1'b1; rd_en = 1'b1; Bank_sel = 1'b1;
    tick(); tick();
    total++;
    if (ref_ou !== 64'h0) begin
      bad++; $display("FAIL reset_hold got=%h exp=%h", ref_ou, 64'h0);
    end
    rst_n = 1'b0;
    tick(); tick();
    total++;
    if (ref_ou !== 64'h0) begin
      bad++; $display("FAIL reset_release got=%h exp=%h", ref_ou, 64'h0);
    end
  endtask

  task automatic test_fill_readback();
    logic [7:0] addrs [5];
    logic [7:0] v;
    addrs = '{8'd0, 8'd1, 8'd3, 8'd4, 8'd5};
    Bank_sel = 1'b0; rd_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      v = addrs[i];
      write_address = v[6:0];
      ref_in = {8{v}};
      tick(); tick(); tick();
    end
    Bank_sel = 1'b1; rd_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      v = addrs[i];
      address = v[6:0];
      tick();
      total++;
      if (ref_ou !== {8{v}}) begin
        bad++; $display("FAIL fill_read@%0d got=%h exp=%h", v, ref_ou, {8{v}});
      end
    end
    rd_en = 1'b1;
  endtask

  task automatic test_write_block();
    Bank_sel = 1'b1; write_address = 7'd1; ref_in = {8{8'hFF}};
    tick();
    rd_en = 1'b0; address = 7'd1;
    tick();
    total++;
    if (ref_ou !== {8{8'h01}}) begin
      bad++; $display("FAIL write_block got=%h exp=%h", ref_ou, {8{8'h01}});
    end
    rd_en = 1'b1;
  endtask

  task automatic test_read_hold();
    rd_en = 1'b0; address = 7'd3;
    tick();
    total++;
    if (ref_ou !== {8{8'h03}}) begin
      bad++; $display("FAIL hold_read got=%h exp=%h", ref_ou, {8{8'h03}});
    end
    rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      address = 7'($urandom_range(0, 127));
      tick();
      total++;
      if (ref_ou !== {8{8'h03}}) begin
        bad++; $display("FAIL hold_keep addr=%0d got=%h exp=%h", address, ref_ou, {8{8'h03}});
      end
    end
  endtask

  task automatic test_collision();
    Bank_sel = 1'b0; write_address = 7'd4; ref_in = {8{8'hAA}};
    rd_en = 1'b0; address = 7'd4;
    tick();
    total++;
    if (ref_ou !== {8{8'h04}}) begin
      bad++; $display("FAIL collide_old got=%h exp=%h", ref_ou, {8{8'h04}});
    end
    Bank_sel = 1'b1;
    tick();
    total++;
    if (ref_ou !== {8{8'hAA}}) begin
      bad++; $display("FAIL collide_new got=%h exp=%h", ref_ou, {8{8'hAA}});
    end
    rd_en = 1'b1;
  endtask

  task automatic test_boundary();
    logic [63:0] d95;
    d95 = rnd64();
    Bank_sel = 1'b0; write_address = 7'd95; ref_in = d95; rd_en = 1'b1;
    tick();
    Bank_sel = 1'b1; rd_en = 1'b0; address = 7'd95;
    tick();
    total++;
    if (ref_ou !== d95) begin
      bad++; $display("FAIL bound_95 got=%h exp=%h", ref_ou, d95);
    end
    Bank_sel = 1'b0; write_address = 7'd100; ref_in = rnd64(); rd_en = 1'b1;
    tick();
    Bank_sel = 1'b1; rd_en = 1'b0; address = 7'd100;
    tick();
    total++;
    if (ref_ou !== 64'h0) begin
      bad++; $display("FAIL bound_100 got=%h exp=%h", ref_ou, 64'h0);
    end
    address = 7'd4;
    tick();
    total++;
    if (ref_ou !== {8{8'hAA}}) begin
      bad++; $display("FAIL bound_alias4 got=%h exp=%h", ref_ou, {8{8'hAA}});
    end
    address = 7'd95;
    tick();
    total++;
    if (ref_ou !== d95) begin
      bad++; $display("FAIL bound_alias95 got=%h exp=%h", ref_ou, d95);
    end
    rd_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    Bank_sel = 1'b1; rd_en = 1'b0; address = 7'd3;
    tick();
    total++;
    if (ref_ou !== {8{8'h03}}) begin
      bad++; $display("FAIL mid_pre got=%h exp=%h", ref_ou, {8{8'h03}});
    end
    rst_n = 1'b1; Bank_sel = 1'b0; write_address = 7'd5; ref_in = rnd64();
    tick();
    total++;
    if (ref_ou !== 64'h0) begin
      bad++; $display("FAIL mid_reset got=%h exp=%h", ref_ou, 64'h0);
    end
    rst_n = 1'b0; Bank_sel = 1'b1; address = 7'd5;
    tick();
    total++;
    if (ref_ou !== {8{8'h05}}) begin
      bad++; $display("FAIL mid_retain got=%h exp=%h", ref_ou, {8{8'h05}});
    end
    rd_en = 1'b1;
  endtask

  task automatic test_random();
    int a;
    for (int n = 0; n < 400; n++) begin
      rst_n         = ($urandom_range(0, 31) == 0);
      Bank_sel      = 1'($urandom_range(0, 1));
      write_address = 7'($urandom_range(0, 103));
      ref_in        = rnd64();
      rd_en         = 1'($urandom_range(0, 1));
      do a = $urandom_range(0, 103); while (a < 96 && !known[a]);
      address = 7'(a);
      tick();
      total++;
      if (ref_ou !== exp_ou) begin
        bad++; $display("FAIL random n=%0d addr=%0d got=%h exp=%h", n, address, ref_ou, exp_ou);
      end
    end
    rst_n = 1'b0; rd_en = 1'b1; Bank_sel = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 96; i++) known[i] = 1'b0;
    exp_ou = 64'h0;
    rst_n = 1'b1; ref_in = 64'h0; Bank_sel = 1'b1;
    write_address = 7'd0; address = 7'd0; rd_en = 1'b1;
    test_reset();
    test_fill_readback();
    test_write_block();
    test_read_hold();
    test_collision();
    test_boundary();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ref_bank.md
# ref_bank

Reference-pixel storage bank for the DMT motion-estimation datapath. Holds up to 96 rows of eight 8-bit reference pixels (64-bit words). One port writes rows streamed in from the reference loader; the other reads rows out to the search array. Two instances are used ping-pong under control of `Bank_sel`.

## Interface

Parameters:
- `PIXEL`, 8: bits per pixel.
- `LANES`, 8: pixels per word; word width = `LANES*PIXEL` = 64.
- `DEPTH`, 96: number of stored words; valid addresses 0..95.
- `AW`, 7: address width.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst_n`  in  1: reset. Synchronous and active-high despite the name: `rst_n=1` at a rising edge resets.
- `ref_in`  in  64: write data; pixel k occupies bits [8k+7:8k].
- `Bank_sel`  in  1: 0 = bank in fill mode (writes enabled); 1 = bank in search mode (writes blocked).
- `write_address`  in  7: write-port word address.
- `address`  in  7: read-port word address.
- `rd_en`  in  1: read enable, active-low; 0 = perform read.
- `ref_ou`  out  64: registered read data.

## Operation

- Storage: `DEPTH` x 64-bit array; contents are not cleared by reset and are undefined until written.
- Write: at each rising edge with reset inactive and `Bank_sel=0`, the array stores `mem[write_address] <= ref_in`.
  - No write when `Bank_sel=1`.
  - No write when `write_address >= DEPTH`; the address is silently dropped.
  - A constant `write_address` over several cycles rewrites the same word each cycle; the last value wins.
- Read: at each rising edge with reset inactive and `rd_en=0`, the read port loads `ref_ou <= mem[address]`.
  - With `address >= DEPTH`, `ref_ou` loads 0.
  - With `rd_en=1`, `ref_ou` holds its previous value.
- Read and write are independent and may occur in the same cycle. On a same-address collision the read is read-first: `ref_ou` gets the old contents and the new data is visible on the next read.
- `Bank_sel` does not gate reads.

## Timing

- Reset: `ref_ou` = 0 at the first edge with `rst_n=1`. While reset is asserted, writes and reads are both suppressed.
- Reset asserted mid-operation takes effect at the next edge; array contents are preserved.
- Write latency: data is readable by a read issued on the edge after the write edge.
- Read latency: 1 cycle. `address` sampled at edge N appears on `ref_ou` after edge N.
- No handshake and no stall; one read and one write are possible per cycle, sustained.
- An X or undriven `rd_en` must not be treated as a read. The bench drives `rd_en=1` whenever reads are not intended.

## Structure

- Shared package `me_pkg` holds:
  - constants `PIXEL=8`, `LANES=8`, `BANK_DEPTH=96`, `BANK_AW=7`;
  - typedef `ref_word_t` (logic [63:0]).
- One sub-module `ref_bank_ram`: simple dual-port RAM (1 write port, 1 registered read port, read-first), inferable as block RAM.
- `ref_bank` wraps the RAM and adds:
  - `Bank_sel` write gating;
  - active-low read enable;
  - out-of-range masking;
  - the reset of `ref_ou`.

## Test plan

- Reset: hold `rst_n=1` two cycles -> `ref_ou`=0; release -> `ref_ou` stays 0 while `rd_en=1`.
- Fill and readback: `Bank_sel=0`; write `{8{8'h00}}`@0, `{8{8'h01}}`@1, `{8{8'h03}}`@3, `{8{8'h04}}`@4, `{8{8'h05}}`@5, three cycles each. Then `rd_en=0` and addresses 0,1,3,4,5 on consecutive cycles -> `ref_ou` gives 0x00.., 0x0101.., 0x0303.., 0x0404.., 0x0505.. one cycle after each address.
- Write block: `Bank_sel=1`, write `{8{8'hFF}}`@1 -> read @1 still returns `{8{8'h01}}`.
- Read hold and collision:
  - `rd_en=1` after reading @3 -> `ref_ou` stays `{8{8'h03}}` regardless of `address`.
  - Same-cycle write `{8{8'hAA}}`@4 and read @4 -> old `{8{8'h04}}`; next read -> `{8{8'hAA}}`.
- Boundary:
  - Write @95 then read @95 -> returns the written data.
  - Write @100 -> no array change; read @100 -> 0.
- Reset mid-run: assert reset for one cycle during reads -> `ref_ou`=0; re-read @5 -> `{8{8'h05}}` (contents retained).
